// File: rtl/ha_pkg.sv
// Shared types and constants for the Tiny Tapeout bit-serial adder.
// Holds the FSM state type, uio bit positions, the output-enable mask and the WIDTH range check.
package ha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // uio_in strobe positions
  localparam int UIO_LOAD_A = 0;
  localparam int UIO_LOAD_B = 1;
  localparam int UIO_START  = 2;

  // uio_out status positions
  localparam int UIO_BUSY   = 4;
  localparam int UIO_DONE   = 5;
  localparam int UIO_COUT   = 6;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // Bit counter only ever holds 0..WIDTH-1 with WIDTH capped at 8.
  localparam int CNT_W = 3;

  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= 8);
  endfunction

endpackage

// File: rtl/ha_serial_slice.sv
// One-bit full adder built from two half adders; purely combinational.
// The carry is held by the caller, so this slice has no state.
module ha_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module ha_serial_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;
  logic g0;
  logic g1;

  ha_half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (p),
    .c (g0)
  );

  // Second stage propagates the incoming carry through the partial sum.
  ha_half_adder u_ha1 (
    .a (p),
    .b (cin),
    .s (s),
    .c (g1)
  );

  assign cout = g0 | g1;
endmodule

// File: rtl/tt_um_ha_serial_adder.sv
// Bit-serial LSB-first adder: operands loaded on strobe edges, result after WIDTH enabled cycles.
// ena low freezes every register; strobes arriving while busy are consumed and dropped.
module tt_um_ha_serial_adder
  import ha_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("tt_um_ha_serial_adder: WIDTH must be in 1..8");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         hist_q, hist_d;

  logic [2:0]         strobe;
  logic [2:0]         edge_det;
  logic               load_edge;
  logic               sum_bit;
  logic               carry_next;
  logic [WIDTH:0]     sum_ext;
  logic               unused_bits;

  assign unused_bits = &{1'b0, uio_in[7:3], ui_in};

  ha_serial_slice u_slice (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (sum_bit),
    .cout (carry_next)
  );

  always_comb begin
    strobe    = uio_in[UIO_START:UIO_LOAD_A];
    edge_det  = strobe & ~hist_q;
    load_edge = edge_det[UIO_LOAD_A] | edge_det[UIO_LOAD_B];
    sum_ext   = {sum_bit, sum_q};

    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sum_d    = sum_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    hist_d   = hist_q;

    if (ena) begin
      hist_d = strobe;
      case (state_q)
        IDLE, DONE: begin
          if (edge_det[UIO_LOAD_A]) op_a_d = ui_in[WIDTH-1:0];
          if (edge_det[UIO_LOAD_B]) op_b_d = ui_in[WIDTH-1:0];
          // A load wins over a coincident start.
          if (load_edge) begin
            state_d = IDLE;
          end else if (edge_det[UIO_START]) begin
            sh_a_d  = op_a_q;
            sh_b_d  = op_b_q;
            sum_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = ADD;
          end
        end
        ADD: begin
          sh_a_d  = sh_a_q >> 1;
          sh_b_d  = sh_b_q >> 1;
          sum_d   = sum_ext[WIDTH:1];
          carry_d = carry_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = sum_ext[WIDTH:1];
            cout_d   = carry_next;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sum_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
    end
  end

  always_comb begin
    uo_out               = '0;
    uo_out[WIDTH-1:0]    = result_q;
    uio_out              = '0;
    uio_out[UIO_BUSY]    = (state_q == ADD);
    uio_out[UIO_DONE]    = (state_q == DONE);
    uio_out[UIO_COUT]    = cout_q;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_ha_serial_adder.sv
// Bench for the serial adder: an 8-bit and a 4-bit build share one stimulus stream and are
// compared every cycle against an arithmetic model, plus directed literal expectations.
module tb_tt_um_ha_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out8, uio_out8, uio_oe8;
  logic [7:0] uo_out4, uio_out4, uio_oe4;

  int n_checks = 0;
  int n_fail   = 0;

  tt_um_ha_serial_adder #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out8),
    .uio_in  (uio_in),
    .uio_out (uio_out8),
    .uio_oe  (uio_oe8)
  );

  tt_um_ha_serial_adder #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out4),
    .uio_in  (uio_in),
    .uio_out (uio_out4),
    .uio_oe  (uio_oe4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 is the 8-bit build, index 1 the 4-bit build.
  logic [7:0] m_a[2], m_b[2], m_res[2], m_psum[2];
  logic       m_busy[2], m_done[2], m_cout[2], m_pc[2];
  logic [2:0] m_hist[2];
  int         m_rem[2];

  task automatic model_step(input int k, input int w);
    logic [8:0] mask;
    logic [8:0] tot;
    logic [2:0] e;
    mask = 9'((1 << w) - 1);
    if (!rst_n) begin
      m_a[k] = 0; m_b[k] = 0; m_res[k] = 0; m_psum[k] = 0;
      m_busy[k] = 0; m_done[k] = 0; m_cout[k] = 0; m_pc[k] = 0;
      m_hist[k] = 0; m_rem[k] = 0;
    end else if (ena) begin
      e = uio_in[2:0] & ~m_hist[k];
      m_hist[k] = uio_in[2:0];
      if (m_busy[k]) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_busy[k] = 0; m_done[k] = 1;
          m_res[k] = m_psum[k]; m_cout[k] = m_pc[k];
        end
      end else begin
        if (e[0]) m_a[k] = ui_in & mask[7:0];
        if (e[1]) m_b[k] = ui_in & mask[7:0];
        if (e[1:0] != 2'b00) begin
          m_done[k] = 0;
        end else if (e[2]) begin
          tot = {1'b0, m_a[k]} + {1'b0, m_b[k]};
          m_psum[k] = tot[7:0] & mask[7:0];
          m_pc[k] = tot[w];
          m_busy[k] = 1; m_done[k] = 0; m_rem[k] = w;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_uio(input int k);
    logic [7:0] v;
    v = 8'h00;
    v[4] = m_busy[k];
    v[5] = m_done[k];
    v[6] = m_cout[k];
    return v;
  endfunction

  always @(posedge clk) begin
    model_step(0, 8);
    model_step(1, 4);
  end

  always @(posedge clk) begin
    #1;
    chk("m8_uo_out", {24'd0, uo_out8}, {24'd0, m_res[0]});
    chk("m8_uio_out", {24'd0, uio_out8}, {24'd0, exp_uio(0)});
    chk("m8_uio_oe", {24'd0, uio_oe8}, 32'hF0);
    chk("m4_uo_out", {24'd0, uo_out4}, {24'd0, m_res[1]});
    chk("m4_uio_out", {24'd0, uio_out4}, {24'd0, exp_uio(1)});
    chk("m4_uio_oe", {24'd0, uio_oe4}, 32'hF0);
  end

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; uio_in = 8'h01; @(negedge clk);
    uio_in = 8'h00; @(negedge clk);
    ui_in = b; uio_in = 8'h02; @(negedge clk);
    uio_in = 8'h00; @(negedge clk);
  endtask

  // mode 0 plain, 1 inject load/start during ADD, 2 hold start into DONE,
  // 3 ena low for three cycles, 4 one-cycle reset at the 4th ADD cycle.
  task automatic run_op(input int mode, output int cyc8, output int cyc4,
                        output int busy8, output int mid_uo);
    uio_in = 8'h04;
    @(negedge clk);
    cyc8 = -1; cyc4 = -1; busy8 = 0; mid_uo = -1;
    for (int k = 0; k <= 40; k++) begin
      if (uio_out8[4]) busy8++;
      if (k == 4) mid_uo = int'(uo_out8);
      if (cyc4 < 0 && uio_out4[5]) cyc4 = k;
      if (uio_out8[5]) begin
        cyc8 = k;
        break;
      end
      if (k == 0) uio_in = 8'h00;
      if (mode == 1) begin
        if (k == 1) begin ui_in = 8'h99; uio_in = 8'h01; end
        if (k == 2) uio_in = 8'h00;
        if (k == 3) uio_in = 8'h04;
        if (k == 4) uio_in = 8'h00;
      end
      if (mode == 2 && k == 6) uio_in = 8'h04;
      if (mode == 3) begin
        if (k == 3) ena = 1'b0;
        if (k == 6) ena = 1'b1;
      end
      if (mode == 4) begin
        if (k == 3) rst_n = 1'b0;
        if (k == 4) begin
          rst_n = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  int c8, c4, b8, mid;

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'h07;
    repeat (10) @(negedge clk);
    chk("rst_uo_out", {24'd0, uo_out8}, 32'h00);
    chk("rst_uio_out", {24'd0, uio_out8}, 32'h00);
    chk("rst_uio_oe", {24'd0, uio_oe8}, 32'hF0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_start", {24'd0, uio_out8}, 32'h00);
    uio_in = 8'h00; ui_in = 8'h00;
    @(negedge clk);

    load_ab(8'h3C, 8'h15);
    run_op(0, c8, c4, b8, mid);
    chk("t2_latency", c8, 8);
    chk("t2_busy_cycles", b8, 8);
    chk("t2_hold_prev", mid, 0);
    chk("t2_sum", {24'd0, uo_out8}, 32'h51);
    chk("t2_cout", {31'd0, uio_out8[6]}, 0);
    chk("t2_w4_sum", {24'd0, uo_out4}, 32'h01);
    chk("t2_w4_cout", {31'd0, uio_out4[6]}, 1);

    load_ab(8'hFF, 8'h01);
    run_op(0, c8, c4, b8, mid);
    chk("t3a_sum", {24'd0, uo_out8}, 32'h00);
    chk("t3a_cout", {31'd0, uio_out8[6]}, 1);
    load_ab(8'h80, 8'h80);
    run_op(0, c8, c4, b8, mid);
    chk("t3b_sum", {24'd0, uo_out8}, 32'h00);
    chk("t3b_cout", {31'd0, uio_out8[6]}, 1);

    load_ab(8'h10, 8'h20);
    run_op(1, c8, c4, b8, mid);
    chk("t4_inject_latency", c8, 8);
    chk("t4_inject_sum", {24'd0, uo_out8}, 32'h30);
    run_op(2, c8, c4, b8, mid);
    chk("t4_hold_sum", {24'd0, uo_out8}, 32'h30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_restart", {30'd0, uio_out8[5:4]}, 32'h2);
    end
    ui_in = 8'h22; uio_in = 8'h05;
    @(negedge clk);
    chk("t4_load_start_idle", {30'd0, uio_out8[5:4]}, 32'h0);
    uio_in = 8'h00;
    @(negedge clk);
    run_op(0, c8, c4, b8, mid);
    chk("t4_new_a_sum", {24'd0, uo_out8}, 32'h42);

    run_op(4, c8, c4, b8, mid);
    @(negedge clk);
    chk("t5_abort_uio", {24'd0, uio_out8}, 32'h00);
    chk("t5_abort_uo", {24'd0, uo_out8}, 32'h00);
    run_op(0, c8, c4, b8, mid);
    chk("t5_zero_sum", {24'd0, uo_out8}, 32'h00);
    chk("t5_zero_latency", c8, 8);

    load_ab(8'hAA, 8'h55);
    run_op(3, c8, c4, b8, mid);
    chk("t6_ena_latency", c8, 11);
    chk("t6_sum", {24'd0, uo_out8}, 32'hFF);
    chk("t6_cout", {31'd0, uio_out8[6]}, 0);
    load_ab(8'h0F, 8'h01);
    run_op(0, c8, c4, b8, mid);
    chk("t6_w4_latency", c4, 4);
    chk("t6_w4_sum", {24'd0, uo_out4}, 32'h00);
    chk("t6_w4_cout", {31'd0, uio_out4[6]}, 1);
    chk("t6_w8_sum", {24'd0, uo_out8}, 32'h10);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
